// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and default constants for the instruction fetch unit.
//   fetch_state_t  - fetch FSM state (RUN, HALTED, FAULT)
//   fetch_entry_t  - one buffered fetch {pc, instr}
//   DEF_RESET_PC   - default first fetch address / lower fetch bound
//   DEF_MEM_LIMIT  - default exclusive upper fetch bound
package fetch_pkg;

    localparam logic [31:0] DEF_RESET_PC  = 32'h0040_0000;
    localparam logic [31:0] DEF_MEM_LIMIT = 32'h0040_0404;

    typedef enum logic [1:0] {
        RUN,
        HALTED,
        FAULT
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_fifo.sv
// fetch_skid_fifo: 2-entry FIFO holding fetched {pc, instr} words for decode.
//   clk, reset     - clock, synchronous active-high reset
//   push, din      - write one entry (caller guarantees room, counting a same-cycle pop)
//   pop            - drop the head entry (caller guarantees non-empty)
//   flush          - discard all entries; wins over push and pop
//   head           - oldest entry
//   count/full/empty - occupancy
module fetch_skid_fifo
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output fetch_entry_t head,
    output logic [1:0]   count,
    output logic         full,
    output logic         empty
);

    fetch_entry_t mem [2];
    logic         wr_ptr;
    logic         rd_ptr;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + 2'(push) - 2'(pop);
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = count == 2'd2;
    assign empty = count == 2'd0;

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: program counter, fetch FSM and 2-entry output buffer for decode.
//   clk, reset                  - clock, synchronous active-high reset
//   currPC / instr              - combinational instruction memory read
//   redirect_valid/redirect_pc  - taken branch/jump; flushes buffer, reloads pc
//   halt                        - level, suppresses fetching while high
//   out_valid/out_ready/out_pc/out_instr - valid/ready handoff to decode
//   fault                       - sticky, illegal fetch address reached
//   number_instructions         - handshake counter, only with FETCH_STATS_EN defined
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
    parameter logic [31:0] MEM_LIMIT = DEF_MEM_LIMIT
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] currPC,
    input  logic [31:0] instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    input  logic        out_ready,
    output logic        fault
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0] number_instructions
`endif
);

    fetch_state_t state, state_next;
    logic [31:0]  pc, pc_next;
    logic         redir, pop, room, attempt, illegal, push;
    fetch_entry_t head;
    logic [1:0]   count;
    logic         full, empty;

    fetch_skid_fifo u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redir),
        .din   ('{pc: pc, instr: instr}),
        .head  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            pc    <= RESET_PC;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    // A redirect wins over everything except FAULT; it also cancels any pop so
    // the flushed head is never counted as delivered.
    always_comb begin
        redir      = redirect_valid && state != FAULT;
        pop        = !empty && out_ready && !redir;
        room       = !full || pop;
        attempt    = state == RUN && !halt && !redir && room;
        illegal    = pc[1:0] != 2'b00 || pc < RESET_PC || pc >= MEM_LIMIT;
        push       = attempt && !illegal;
        state_next = (state == FAULT || (attempt && illegal)) ? FAULT :
                     halt ? HALTED : RUN;
        pc_next    = redir ? redirect_pc : push ? pc + 32'd4 : pc;
    end

    assign currPC    = pc;
    assign out_valid = count != 2'd0;
    assign out_pc    = empty ? 32'd0 : head.pc;
    assign out_instr = empty ? 32'd0 : head.instr;
    assign fault     = state == FAULT;

`ifdef FETCH_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) number_instructions <= 32'd0;
        else if (pop) number_instructions <= number_instructions + 32'd1;
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: scoreboard bench with a queue-level reference model and random stimulus.
module tb_instr_fetch_unit;

    localparam logic [31:0] RPC = 32'h0040_0000;
    localparam logic [31:0] LIM = 32'h0040_0404;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] curr_pc;
    logic [31:0] instr;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        halt = 1'b0;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_ready = 1'b0;
    logic        fault;
    logic [31:0] number_instructions;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] memw(input logic [31:0] a);
        return {a[15:0] ^ 16'hA5C3, a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    assign instr = memw(curr_pc);

    instr_fetch_unit dut (
        .clk                 (clk),
        .reset               (reset),
        .currPC              (curr_pc),
        .instr               (instr),
        .redirect_valid      (redirect_valid),
        .redirect_pc         (redirect_pc),
        .halt                (halt),
        .out_valid           (out_valid),
        .out_pc              (out_pc),
        .out_instr           (out_instr),
        .out_ready           (out_ready),
        .fault               (fault)
`ifdef FETCH_STATS_EN
        ,
        .number_instructions (number_instructions)
`endif
    );

`ifndef FETCH_STATS_EN
    assign number_instructions = 32'd0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: expected delivery queue plus architectural pc/flags.
    logic [63:0] sb[$];
    logic [31:0] m_pc = RPC;
    bit          m_fault = 0;
    bit          m_halted = 0;
    logic [31:0] m_count = 0;
    bit          started = 0;

    always @(negedge clk) begin
        bit redir;
        bit hs;
        if (started) begin
            chk("out_valid", {31'd0, out_valid}, {31'd0, sb.size() != 0});
            if (sb.size() != 0 && out_valid) begin
                chk("out_pc", out_pc, sb[0][63:32]);
                chk("out_instr", out_instr, sb[0][31:0]);
            end
            chk("currPC", curr_pc, m_pc);
            chk("fault", {31'd0, fault}, {31'd0, m_fault});
`ifdef FETCH_STATS_EN
            chk("number_instructions", number_instructions, m_count);
`endif
        end
        if (reset) begin
            sb.delete();
            m_pc = RPC;
            m_fault = 0;
            m_halted = 0;
            m_count = 0;
            started = 1;
        end else if (started) begin
            redir = redirect_valid && !m_fault;
            hs = sb.size() != 0 && out_ready && !redir;
            if (redir) begin
                sb.delete();
                m_pc = redirect_pc;
            end else begin
                if (hs) begin
                    void'(sb.pop_front());
                    m_count++;
                end
                if (!m_fault && !m_halted && !halt && sb.size() < 2) begin
                    if (m_pc[1:0] == 2'b00 && m_pc >= RPC && m_pc < LIM) begin
                        sb.push_back({m_pc, memw(m_pc)});
                        m_pc += 4;
                    end else m_fault = 1;
                end
            end
            if (!m_fault) m_halted = halt;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        redirect_valid = 1'b0;
        halt = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    initial begin
        int n;
        #1;
        do_reset();
        chk("reset_out_pc", out_pc, 32'd0);
        chk("reset_out_instr", out_instr, 32'd0);
        chk("reset_currpc", curr_pc, RPC);
        out_ready = 1'b1;
        repeat (4) tick();

        do_reset();
        out_ready = 1'b0;
        repeat (5) tick();
        chk("bp_currpc", curr_pc, RPC + 32'd8);
        chk("bp_head", out_pc, RPC);
        out_ready = 1'b1;
        repeat (3) tick();

        out_ready = 1'b0;
        repeat (3) tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0040_0100;
        tick();
        redirect_valid = 1'b0;
        chk("redir_bubble", {31'd0, out_valid}, 32'd0);
        tick();
        chk("redir_target", out_pc, 32'h0040_0100);
        out_ready = 1'b1;
        repeat (3) tick();

        redirect_valid = 1'b1;
        redirect_pc = 32'h0040_0102;
        tick();
        redirect_valid = 1'b0;
        chk("mis_fault_early", {31'd0, fault}, 32'd0);
        tick();
        chk("mis_fault", {31'd0, fault}, 32'd1);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0040_0000;
        tick();
        redirect_valid = 1'b0;
        tick();
        chk("fault_ignores_redirect", curr_pc, 32'h0040_0102);

        do_reset();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0040_03F0;
        tick();
        redirect_valid = 1'b0;
        out_ready = 1'b0;
        tick();
        out_ready = 1'b1;
        n = 0;
        while (!fault && n < 50) begin
            tick();
            n++;
        end
        chk("end_fault", {31'd0, fault}, 32'd1);
        chk("end_currpc", curr_pc, LIM);
        repeat (4) tick();
        chk("end_currpc_hold", curr_pc, LIM);

`ifdef FETCH_STATS_EN
        do_reset();
        out_ready = 1'b1;
        repeat (11) tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0040_0200;
        tick();
        redirect_valid = 1'b0;
        repeat (4) tick();
        out_ready = 1'b0;
        chk("stats_13", number_instructions, 32'd13);
        reset = 1'b1;
        tick();
        chk("stats_reset", number_instructions, 32'd0);
        reset = 1'b0;
`endif

        do_reset();
        for (int i = 0; i < 3000; i++) begin
            out_ready = $urandom_range(0, 3) != 0;
            halt = $urandom_range(0, 9) == 0;
            reset = $urandom_range(0, 149) == 0;
            redirect_valid = $urandom_range(0, 19) == 0;
            case ($urandom_range(0, 15))
                0:       redirect_pc = RPC + 32'($urandom_range(0, 256) * 4) + 32'd2;
                1:       redirect_pc = LIM;
                2:       redirect_pc = RPC - 32'd4;
                3:       redirect_pc = LIM - 32'd12;
                default: redirect_pc = RPC + 32'($urandom_range(0, 256) * 4);
            endcase
            tick();
        end
        reset = 1'b0;
        redirect_valid = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Initiator side of the instruction-memory read interface: owns the program counter, drives `currPC` into the combinational-read instruction memory, and captures the returned `instr` word. Fetched words go into a 2-entry buffer and are handed to decode over a valid/ready handshake. Also handles branch/jump redirects, halt, and bounds/alignment faults.

## Interface
Parameters:
- `RESET_PC`, 32'h0040_0000: first fetch address after reset; also the lower bound of legal fetch space.
- `MEM_LIMIT`, 32'h0040_0404: exclusive upper bound of legal fetch space (257 words).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `currPC`  out  32  byte address to instruction memory (memory indexes `currPC[31:2]`).
- `instr`  in  32  memory word for `currPC`, valid in the same cycle.
- `redirect_valid`  in  1  branch/jump taken this cycle.
- `redirect_pc`  in  32  target byte address.
- `halt`  in  1  level; suppresses new fetches while high.
- `out_valid`  out  1  buffer head is valid.
- `out_pc`  out  32  PC of the buffer-head word.
- `out_instr`  out  32  buffer-head word.
- `out_ready`  in  1  decode accepts; transfer happens when `out_valid && out_ready`.
- `fault`  out  1  sticky; an illegal fetch address was reached.
- `number_instructions`  out  32  only present with `FETCH_STATS_EN`.

## Operation
- States: RUN, HALTED, FAULT. Reset enters RUN with `pc=RESET_PC`, buffer empty, `fault=0`, `out_valid=0`, `out_pc=0`, `out_instr=0`, counter 0.
- A fetch fires in a cycle when all of the following hold:
  - state is RUN;
  - `halt=0`;
  - `redirect_valid=0`;
  - buffer has room (count<2, or count==2 with a pop this cycle).
- On a fetch, {`pc`, `instr`} is pushed and `pc<=pc+4`.
- Legality check applies to `pc` in RUN: `pc[1:0]!=0`, `pc<RESET_PC`, or `pc>=MEM_LIMIT`. An illegal `pc` causes no push and a transition to FAULT with `fault<=1`. `pc+4` wrapping past 0xFFFF_FFFC is therefore caught as a fault.
- HALTED: entered when `halt=1` in RUN; returns to RUN on the first cycle `halt=0`. `pc` is held.
- Redirect has highest priority, in any state except FAULT:
  - the fetch in that cycle is discarded;
  - the buffer is flushed, including the entry at the head;
  - any pop in that cycle is ignored;
  - `pc<=redirect_pc`.
- Legality of a redirect target is checked on the following fetch attempt, not at redirect time.
- FAULT: no fetches. Redirects are ignored. The buffer keeps draining to decode. Only `reset` exits FAULT.
- `currPC` always equals the internal `pc`, including in HALTED and FAULT.
- Buffer is FIFO-ordered. Simultaneous push and pop with count==2 is legal, and count stays 2.

## Timing
- Fetch-to-output latency is 1 cycle. The word for `pc` fetched in cycle N is on `out_*` in cycle N+1.
- With `out_ready` held at 1, throughput is one instruction per cycle.
- Back-pressure: with `out_ready=0`, fetching continues until count==2 (two more words), then `pc` holds. The first cycle `out_ready=1` pops one entry and refills in the same cycle.
- Redirect asserted in cycle N: `out_valid=0` in N+1, target fetched in N+1, target word visible in N+2.
- `out_*` holds stable while `out_valid && !out_ready`.
- `fault` rises in the cycle after the illegal fetch attempt.
- Reset asserted mid-operation takes effect at the next edge and overrides redirect, halt and pop.

## Configuration
- `FETCH_STATS_EN` defined:
  - `number_instructions` port exists;
  - it increments by 1 per `out_valid && out_ready` handshake;
  - it wraps modulo 2^32 and resets to 0;
  - handshakes on entries flushed by a redirect are not counted.
- `FETCH_STATS_EN` undefined: the port and counter are removed, and behaviour is otherwise identical.

## Structure
- Package `fetch_pkg`:
  - state enum (RUN, HALTED, FAULT);
  - default `RESET_PC` and `MEM_LIMIT` constants;
  - buffer-entry struct {pc[31:0], instr[31:0]}.
- Sub-module `fetch_skid_fifo`: 2-entry, 64-bit wide, with push, pop and flush inputs and count/full/empty outputs. `instr_fetch_unit` contains the PC, FSM, legality check and statistics counter.

## Test plan
- Reset, then `out_ready=1` for 4 cycles: `out_pc` shows 0x0040_0000, …_0004, …_0008, each 1 cycle after its fetch, with `instr` matching memory.
- `out_ready=0` for 5 cycles: `currPC` stops at RESET_PC+8 with count 2. Then `out_ready=1`: head is RESET_PC, and no word is lost or duplicated.
- `redirect_valid=1`, `redirect_pc=0x0040_0100` with a full buffer: `out_valid=0` next cycle, then `out_pc=0x0040_0100`.
- `redirect_pc=0x0040_0102`: `fault=1` two cycles later, no further pushes, remaining entries still drain, and a later redirect is ignored.
- Sequential fetch reaching 0x0040_0404 (last legal word 0x0040_0400 fetched): `fault=1` and `currPC` holds at 0x0040_0404.
- With `FETCH_STATS_EN`: 10 handshakes, then a redirect flush, then 3 handshakes gives `number_instructions=13`. Asserting reset mid-stream gives 0.
